// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: controller state encoding and command opcodes.
// Command opcodes 0-7 pass straight through to the ALU opc field; 8 is the iterative MUL;
// 9-15 are rejected with an error response.
package alu_seq_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StIter,
      StResp
   } state_e;

   localparam logic [OP_W-1:0] OP_ADD = 4'h0;
   localparam logic [OP_W-1:0] OP_INC = 4'h1;
   localparam logic [OP_W-1:0] OP_SEL = 4'h2;
   localparam logic [OP_W-1:0] OP_AND = 4'h4;
   localparam logic [OP_W-1:0] OP_OR  = 4'h5;
   localparam logic [OP_W-1:0] OP_NOT = 4'h6;
   localparam logic [OP_W-1:0] OP_CLR = 4'h7;
   localparam logic [OP_W-1:0] OP_MUL = 4'h8;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command and response channels of the ALU sequencer.
//   cmd_*  : valid/ready command (op, dst, srcA, srcB, cin), driven by the master
//   rsp_*  : valid/ready response (data, zero, negative, error), driven by the slave
// The slave modport is the sequencer's view; the master modport is the requester's view.
interface alu_sequencer_if
   import alu_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 2
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic [OP_W-1:0]   cmd_op;
   logic [REG_AW-1:0] cmd_dst;
   logic [REG_AW-1:0] cmd_srcA;
   logic [REG_AW-1:0] cmd_srcB;
   logic              cmd_cin;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_zer;
   logic              rsp_neg;
   logic              rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_dst, cmd_srcA, cmd_srcB, cmd_cin, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_zer, rsp_neg, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_dst, cmd_srcA, cmd_srcB, cmd_cin, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_zer, rsp_neg, rsp_err
   );

endinterface

// File: rtl/alu_seq_regfile.sv
// Small register file for the ALU sequencer.
//   clk, rst_n          : clock, asynchronous active-low reset (clears every register)
//   ra_addr_i/ra_data_o : combinational read port A
//   rb_addr_i/rb_data_o : combinational read port B
//   rd_addr_i/rd_data_o : combinational debug read port
//   we_i, wa_i, wd_i    : synchronous write port
module alu_seq_regfile
   import alu_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] ra_addr_i,
   output logic [DATA_W-1:0] ra_data_o,
   input  logic [REG_AW-1:0] rb_addr_i,
   output logic [DATA_W-1:0] rb_data_o,
   input  logic [REG_AW-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   input  logic              we_i,
   input  logic [REG_AW-1:0] wa_i,
   input  logic [DATA_W-1:0] wd_i
);

   localparam int unsigned NumRegs = 1 << REG_AW;

   logic [DATA_W-1:0] regs_q [NumRegs];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign ra_data_o = regs_q[ra_addr_i];
   assign rb_data_o = regs_q[rb_addr_i];
   assign rd_data_o = regs_q[rd_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven controller sequencing an external 16-bit combinational ALU against a local
// register file. One command at a time; result written back and returned on the response channel.
// MUL is done by shift-add using the ALU adder, one step per cycle.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus_io         : command/response channels (slave side)
//   alu_opc/inA/inB/inC : drive to the ALU (zero outside EXEC and ITER)
//   alu_outW/zer/neg    : result from the ALU
//   busy           : controller not idle
//   rd_addr/rd_data: combinational debug read of the register file
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 2,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_sequencer_if.slave    bus_io,
   output logic [2:0]        alu_opc,
   output logic [DATA_W-1:0] alu_inA,
   output logic [DATA_W-1:0] alu_inB,
   output logic              alu_inC,
   input  logic [DATA_W-1:0] alu_outW,
   input  logic              alu_zer,
   input  logic              alu_neg,
   output logic              busy,
   input  logic [REG_AW-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [REG_AW-1:0] dst_q, dst_d;
   logic              cin_q, cin_d;
   // opa/opb hold the ALU operands in EXEC and double as multiplicand/multiplier in ITER.
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_zer_q, rsp_zer_d;
   logic              rsp_neg_q, rsp_neg_d;
   logic              rsp_err_q, rsp_err_d;

   logic [DATA_W-1:0] rf_a, rf_b;
   logic              we;
   logic [DATA_W-1:0] wd;
   logic [DATA_W-1:0] acc_nx;

   alu_seq_regfile #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .ra_addr_i (bus_io.cmd_srcA),
      .ra_data_o (rf_a),
      .rb_addr_i (bus_io.cmd_srcB),
      .rb_data_o (rf_b),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data),
      .we_i      (we),
      .wa_i      (dst_q),
      .wd_i      (wd)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      dst_d      = dst_q;
      cin_d      = cin_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      acc_d      = acc_q;
      rsp_data_d = rsp_data_q;
      rsp_zer_d  = rsp_zer_q;
      rsp_neg_d  = rsp_neg_q;
      rsp_err_d  = rsp_err_q;
      we         = 1'b0;
      wd         = alu_outW;
      acc_nx     = acc_q;
      alu_opc    = '0;
      alu_inA    = '0;
      alu_inB    = '0;
      alu_inC    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus_io.cmd_valid) begin
               // Operands are captured here, before any write, so dst may alias a source.
               opa_d = rf_a;
               opb_d = rf_b;
               op_d  = bus_io.cmd_op[2:0];
               dst_d = bus_io.cmd_dst;
               cin_d = bus_io.cmd_cin;
               acc_d = '0;
               if (!bus_io.cmd_op[3]) begin
                  state_d = StExec;
               end else if (MUL_EN && bus_io.cmd_op == OP_MUL) begin
                  state_d = StIter;
               end else begin
                  rsp_data_d = '0;
                  rsp_zer_d  = 1'b0;
                  rsp_neg_d  = 1'b0;
                  rsp_err_d  = 1'b1;
                  state_d    = StResp;
               end
            end
         end
         StExec: begin
            alu_opc    = op_q;
            alu_inA    = opa_q;
            alu_inB    = opb_q;
            alu_inC    = cin_q;
            we         = 1'b1;
            wd         = alu_outW;
            rsp_data_d = alu_outW;
            rsp_zer_d  = alu_zer;
            rsp_neg_d  = alu_neg;
            rsp_err_d  = 1'b0;
            state_d    = StResp;
         end
         StIter: begin
            alu_opc = OP_ADD[2:0];
            alu_inA = acc_q;
            alu_inB = opa_q;
            alu_inC = 1'b0;
            acc_nx  = opb_q[0] ? alu_outW : acc_q;
            acc_d   = acc_nx;
            opa_d   = opa_q << 1;
            opb_d   = opb_q >> 1;
            // Stop once no multiplier bits remain above the one just consumed.
            if (opb_q[DATA_W-1:1] == '0) begin
               we         = 1'b1;
               wd         = acc_nx;
               rsp_data_d = acc_nx;
               rsp_zer_d  = (acc_nx == '0);
               rsp_neg_d  = acc_nx[DATA_W-1];
               rsp_err_d  = 1'b0;
               state_d    = StResp;
            end
         end
         StResp: begin
            if (bus_io.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         op_q       <= '0;
         dst_q      <= '0;
         cin_q      <= 1'b0;
         opa_q      <= '0;
         opb_q      <= '0;
         acc_q      <= '0;
         rsp_data_q <= '0;
         rsp_zer_q  <= 1'b0;
         rsp_neg_q  <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         dst_q      <= dst_d;
         cin_q      <= cin_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         acc_q      <= acc_d;
         rsp_data_q <= rsp_data_d;
         rsp_zer_q  <= rsp_zer_d;
         rsp_neg_q  <= rsp_neg_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign bus_io.cmd_ready = (state_q == StIdle);
   assign bus_io.rsp_valid = (state_q == StResp);
   assign bus_io.rsp_data  = rsp_data_q;
   assign bus_io.rsp_zer   = rsp_zer_q;
   assign bus_io.rsp_neg   = rsp_neg_q;
   assign bus_io.rsp_err   = rsp_err_q;
   assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: stand-in combinational ALU, a table of hand-derived vectors,
// hand-written backpressure and reset sequences, then random commands against a reference model.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [2:0]  alu_opc;
   logic [15:0] alu_inA, alu_inB, alu_outW;
   logic        alu_inC, alu_zer, alu_neg;
   logic        busy;
   logic [1:0]  rd_addr;
   logic [15:0] rd_data;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] mregs [4];

   alu_sequencer_if #(.DATA_W(16), .REG_AW(2)) bus ();

   alu_sequencer #(
      .DATA_W (16),
      .REG_AW (2),
      .MUL_EN (1'b1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus_io   (bus),
      .alu_opc  (alu_opc),
      .alu_inA  (alu_inA),
      .alu_inB  (alu_inB),
      .alu_inC  (alu_inC),
      .alu_outW (alu_outW),
      .alu_zer  (alu_zer),
      .alu_neg  (alu_neg),
      .busy     (busy),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the team ALU: 0 add, 1 inc, 2 pass B, 3 xor, 4 and, 5 or, 6 not A, 7 clear.
   function automatic logic [15:0] alu_f(input logic [2:0] opc, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
      case (opc)
         3'd0:    alu_f = a + b + {15'd0, c};
         3'd1:    alu_f = a + 16'd1;
         3'd2:    alu_f = b;
         3'd3:    alu_f = a ^ b;
         3'd4:    alu_f = a & b;
         3'd5:    alu_f = a | b;
         3'd6:    alu_f = ~a;
         default: alu_f = '0;
      endcase
   endfunction

   always_comb begin
      alu_outW = alu_f(alu_opc, alu_inA, alu_inB, alu_inC);
      alu_zer  = (alu_outW == 16'd0);
      alu_neg  = alu_outW[15];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_reg(input logic [1:0] a, input logic [15:0] exp);
      rd_addr = a;
      #1;
      chk($sformatf("reg[%0d]", a), rd_data, exp);
   endtask

   // Reference: plain arithmetic product for MUL, step count = bit length of B (at least 1).
   task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output logic [15:0] r, output logic z, output logic n,
                        output logic e, output int lat);
      logic [31:0] p;
      int          steps;
      e = 1'b0;
      if (op < 4'd8) begin
         r   = alu_f(op[2:0], a, b, cin);
         lat = 2;
      end else if (op == 4'd8) begin
         p     = {16'd0, a} * {16'd0, b};
         r     = p[15:0];
         steps = 1;
         for (int i = 0; i < 16; i++) if (b[i]) steps = i + 1;
         lat = steps + 1;
      end else begin
         r   = '0;
         e   = 1'b1;
         lat = 1;
      end
      z = (r == 16'd0);
      n = r[15];
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!bus.rsp_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!bus.rsp_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rsp_timeout: got no rsp_valid, expected it within 64 cycles");
      end
   endtask

   task automatic exec_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                           input logic [1:0] sb, input logic cin, input int ack_dly,
                           output logic [15:0] d, output logic z, output logic n,
                           output logic e, output int lat);
      @(negedge clk);
      chk("cmd_ready_idle", bus.cmd_ready, 1);
      bus.cmd_op    = op;
      bus.cmd_dst   = dst;
      bus.cmd_srcA  = sa;
      bus.cmd_srcB  = sb;
      bus.cmd_cin   = cin;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      wait_rsp(lat);
      d = bus.rsp_data;
      z = bus.rsp_zer;
      n = bus.rsp_neg;
      e = bus.rsp_err;
      chk("alu_drive_idle", {alu_opc, alu_inA, alu_inB, alu_inC}, 0);
      repeat (ack_dly) begin
         @(posedge clk);
         #1;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      chk("busy_after_ack", busy, 0);
   endtask

   task automatic do_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic cin, input int ack_dly);
      logic [15:0] er, d;
      logic        ez, en, ee, z, n, e;
      int          el, lat;
      model(op, mregs[sa], mregs[sb], cin, er, ez, en, ee, el);
      exec_cmd(op, dst, sa, sb, cin, ack_dly, d, z, n, e, lat);
      chk($sformatf("op%0h data", op), d, er);
      chk($sformatf("op%0h err", op), e, ee);
      chk($sformatf("op%0h lat", op), lat, el);
      if (!ee) chk($sformatf("op%0h flags", op), {z, n}, {ez, en});
      if (!ee) mregs[dst] = er;
      chk_reg(dst, mregs[dst]);
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [1:0]  dst, sa, sb;
      logic        cin;
      logic [15:0] data;
      logic        zer, neg, err;
      int          lat;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                               input logic [1:0] sb, input logic cin, input logic [15:0] data,
                               input logic zer, input logic neg, input logic err, input int lat);
      vec_t v;
      v.op = op; v.dst = dst; v.sa = sa; v.sb = sb; v.cin = cin;
      v.data = data; v.zer = zer; v.neg = neg; v.err = err; v.lat = lat;
      return v;
   endfunction

   initial begin
      vec_t        vecs [$];
      logic [15:0] d, er, hold;
      logic        z, n, e, ez, en, ee;
      int          lat, el;

      //                 op     dst sa sb cin data      z  n  e  lat
      vecs.push_back(mk(4'h0, 1, 2, 2, 1, 16'd1,    0, 0, 0, 2));
      vecs.push_back(mk(4'h0, 0, 1, 1, 1, 16'd3,    0, 0, 0, 2));
      vecs.push_back(mk(4'h0, 0, 0, 1, 1, 16'd5,    0, 0, 0, 2));
      vecs.push_back(mk(4'h0, 1, 1, 1, 1, 16'd3,    0, 0, 0, 2));
      vecs.push_back(mk(4'h0, 2, 0, 1, 1, 16'd9,    0, 0, 0, 2));
      vecs.push_back(mk(4'h8, 3, 0, 0, 0, 16'd25,   0, 0, 0, 4));
      vecs.push_back(mk(4'h0, 2, 2, 1, 0, 16'd12,   0, 0, 0, 2));
      vecs.push_back(mk(4'h8, 0, 3, 2, 0, 16'd300,  0, 0, 0, 5));
      vecs.push_back(mk(4'h0, 1, 1, 1, 1, 16'd7,    0, 0, 0, 2));
      vecs.push_back(mk(4'h8, 2, 0, 1, 0, 16'd2100, 0, 0, 0, 4));
      vecs.push_back(mk(4'h0, 3, 1, 1, 1, 16'd15,   0, 0, 0, 2));
      vecs.push_back(mk(4'h1, 3, 3, 0, 0, 16'd16,   0, 0, 0, 2));
      vecs.push_back(mk(4'h8, 3, 3, 3, 0, 16'd256,  0, 0, 0, 6));
      vecs.push_back(mk(4'h8, 3, 3, 3, 0, 16'd0,    1, 0, 0, 10));
      vecs.push_back(mk(4'hB, 0, 1, 1, 0, 16'd0,    0, 0, 1, 1));
      vecs.push_back(mk(4'h7, 2, 0, 0, 0, 16'd0,    1, 0, 0, 2));
      vecs.push_back(mk(4'h8, 0, 1, 2, 0, 16'd0,    1, 0, 0, 2));
      vecs.push_back(mk(4'h0, 3, 1, 1, 1, 16'd15,   0, 0, 0, 2));
      vecs.push_back(mk(4'h1, 0, 3, 0, 0, 16'd16,   0, 0, 0, 2));
      vecs.push_back(mk(4'h1, 0, 0, 0, 0, 16'd17,   0, 0, 0, 2));
      vecs.push_back(mk(4'h8, 0, 3, 0, 0, 16'd255,  0, 0, 0, 6));
      vecs.push_back(mk(4'h6, 0, 0, 0, 0, 16'hFF00, 0, 1, 0, 2));
      vecs.push_back(mk(4'h4, 1, 0, 3, 0, 16'h0000, 1, 0, 0, 2));
      vecs.push_back(mk(4'h5, 2, 0, 3, 0, 16'hFF0F, 0, 1, 0, 2));
      vecs.push_back(mk(4'h2, 1, 0, 3, 0, 16'd15,   0, 0, 0, 2));
      vecs.push_back(mk(4'h8, 3, 2, 1, 0, 16'hF1E1, 0, 1, 0, 5));

      rst_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_dst = '0;
      bus.cmd_srcA = '0; bus.cmd_srcB = '0; bus.cmd_cin = 1'b0;
      bus.rsp_ready = 1'b0;
      rd_addr = '0;
      for (int i = 0; i < 4; i++) mregs[i] = '0;
      #12;
      chk("reset cmd_ready", bus.cmd_ready, 1);
      chk("reset rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_zer, bus.rsp_neg, bus.rsp_err}, 0);
      chk("reset busy", busy, 0);
      chk("reset alu drive", {alu_opc, alu_inA, alu_inB, alu_inC}, 0);
      for (int i = 0; i < 4; i++) chk_reg(2'(i), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table of hand-derived vectors; register shadow follows the table's expectations.
      foreach (vecs[k]) begin
         exec_cmd(vecs[k].op, vecs[k].dst, vecs[k].sa, vecs[k].sb, vecs[k].cin, k % 3,
                  d, z, n, e, lat);
         chk($sformatf("vec%0d data", k), d, vecs[k].data);
         chk($sformatf("vec%0d flags", k), {z, n, e}, {vecs[k].zer, vecs[k].neg, vecs[k].err});
         chk($sformatf("vec%0d lat", k), lat, vecs[k].lat);
         if (!vecs[k].err) mregs[vecs[k].dst] = vecs[k].data;
         for (int i = 0; i < 4; i++) chk_reg(2'(i), mregs[i]);
      end

      // Backpressure: response held 5 cycles while a new command waits.
      model(4'h0, mregs[1], mregs[1], 1'b1, er, ez, en, ee, el);
      @(negedge clk);
      bus.cmd_op = 4'h0; bus.cmd_dst = 2'd3; bus.cmd_srcA = 2'd1; bus.cmd_srcB = 2'd1;
      bus.cmd_cin = 1'b1; bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      wait_rsp(lat);
      mregs[3] = er;
      hold = bus.rsp_data;
      chk("bp data", hold, er);
      bus.cmd_op = 4'h1; bus.cmd_dst = 2'd2; bus.cmd_srcA = 2'd3; bus.cmd_cin = 1'b0;
      bus.cmd_valid = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("bp cmd_ready", bus.cmd_ready, 0);
         chk("bp rsp held", {bus.rsp_valid, bus.rsp_data, bus.rsp_err}, {1'b1, er, 1'b0});
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      chk("bp ready after ack", {bus.cmd_ready, busy}, {1'b1, 1'b0});
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      chk("bp next accepted", busy, 1);
      model(4'h1, mregs[3], mregs[1], 1'b0, er, ez, en, ee, el);
      wait_rsp(lat);
      chk("bp next data", bus.rsp_data, er);
      chk("bp next lat", lat, 2);
      mregs[2] = er;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      chk_reg(2'd2, mregs[2]);

      // Reset during a 16-step MUL: build 0x8000 in r0 by doubling 0xFF00.
      for (int i = 0; i < 7; i++) do_cmd(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 0);
      chk("r0 is 0x8000", mregs[0], 16'h8000);
      @(negedge clk);
      bus.cmd_op = 4'h8; bus.cmd_dst = 2'd1; bus.cmd_srcA = 2'd1; bus.cmd_srcB = 2'd0;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("mid-mul busy", {busy, bus.rsp_valid}, {1'b1, 1'b0});
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst busy", busy, 0);
      chk("rst rsp_valid", bus.rsp_valid, 0);
      for (int i = 0; i < 4; i++) begin
         mregs[i] = '0;
         chk_reg(2'(i), 16'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_cmd(4'h0, 2'd2, 2'd0, 2'd0, 1'b1, 0);
      do_cmd(4'h8, 2'd3, 2'd2, 2'd2, 1'b0, 1);

      // Random commands against the reference model.
      for (int t = 0; t < 150; t++) begin
         logic [3:0] op;
         if ($urandom_range(0, 9) == 0)      op = 4'($urandom_range(9, 15));
         else if ($urandom_range(0, 3) == 0) op = 4'h8;
         else                                op = 4'($urandom_range(0, 7));
         do_cmd(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
